// File: rtl/slc3_mem_io_ctrl_if.sv
// CPU-side request/acknowledge bus of the SLC-3 memory/IO controller (MAR/MDR side).
interface slc3_mem_io_ctrl_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              busy;

  modport master (output req, we, addr, wdata, input rdata, ack, busy);
  modport slave  (input req, we, addr, wdata, output rdata, ack, busy);
endinterface

// File: rtl/slc3_mem_io_ctrl.sv
// SLC-3 memory/IO controller: IO window decode, wait-stated SRAM access FSM, hex display registers.
// Optional SRAM access counter at 16'hFFF9 when SLC3_MIO_STATS_EN is defined.
module slc3_mem_io_ctrl #(
  parameter int unsigned     ADDR_W        = 16,
  parameter int unsigned     DATA_W        = 16,
  parameter int unsigned     WAIT_STATES   = 2,
  parameter int unsigned     NUM_HEX_WORDS = 2,
  parameter logic [ADDR_W-1:0] SW_ADDR     = ADDR_W'(16'hFFFF),
  parameter logic [ADDR_W-1:0] HEX_BASE    = ADDR_W'(16'hFFFA)
) (
  input  logic                            Clk,
  input  logic                            Reset,
  slc3_mem_io_ctrl_if.slave               bus,
  input  logic [DATA_W-1:0]               switches,
  output logic [NUM_HEX_WORDS*DATA_W-1:0] hex_out,
  output logic                            CE,
  output logic                            OE,
  output logic                            WE,
  output logic                            UB,
  output logic                            LB,
  output logic [19:0]                     ADDR,
  input  logic [DATA_W-1:0]               sram_din,
  output logic [DATA_W-1:0]               sram_dout,
  output logic                            sram_drive
);

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned HEX_IDX_W = (NUM_HEX_WORDS > 1) ? $clog2(NUM_HEX_WORDS) : 1;
  localparam logic [ADDR_W:0] HEX_END = {1'b0, HEX_BASE} + (ADDR_W+1)'(NUM_HEX_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_we;
  logic                r_ack, r_busy;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_ce_n, r_oe_n, r_we_n, r_bytes_n, r_drive;
  logic [19:0]         r_addr;
  logic [DATA_W-1:0]   r_dout;
  logic [DATA_W-1:0]   r_hex [NUM_HEX_WORDS];

  logic                w_accept, w_finish, w_wr;
  logic                w_is_sw, w_is_hex, w_is_stats, w_is_io;
  logic [HEX_IDX_W-1:0] w_hex_idx;
  logic [DATA_W-1:0]   w_io_rdata;
  logic                w_ce_n_nxt, w_oe_n_nxt, w_we_n_nxt, w_bytes_n_nxt, w_drive_nxt;

`ifdef SLC3_MIO_STATS_EN
  localparam logic [ADDR_W-1:0] STATS_ADDR = ADDR_W'(16'hFFF9);
  logic [15:0] r_stats;
  assign w_is_stats = (bus.addr == STATS_ADDR);
`else
  assign w_is_stats = 1'b0;
`endif

  // IO window decode; any IO hit overrides the SRAM path
  assign w_is_sw   = (bus.addr == SW_ADDR);
  assign w_is_hex  = ({1'b0, bus.addr} >= {1'b0, HEX_BASE}) && ({1'b0, bus.addr} < HEX_END);
  assign w_hex_idx = HEX_IDX_W'(bus.addr - HEX_BASE);
  assign w_is_io   = w_is_sw | w_is_hex | w_is_stats;

  always_comb begin
    w_io_rdata = '0;
    if (w_is_sw)       w_io_rdata = switches;
    else if (w_is_hex) w_io_rdata = r_hex[w_hex_idx];
`ifdef SLC3_MIO_STATS_EN
    else if (w_is_stats) w_io_rdata = DATA_W'(r_stats);
`endif
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state plus strobe values, registered so they line up with the state they belong to
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_accept      = 1'b0;
    w_finish      = 1'b0;
    w_ce_n_nxt    = 1'b1;
    w_oe_n_nxt    = 1'b1;
    w_we_n_nxt    = 1'b1;
    w_bytes_n_nxt = 1'b1;
    w_drive_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = w_is_io ? S_DONE : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (r_cnt == CNT_W'(WAIT_STATES)) begin
          w_finish    = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_wr = w_accept ? bus.we : r_we;
    if (w_state_nxt == S_ACCESS) begin
      w_ce_n_nxt    = 1'b0;
      w_bytes_n_nxt = 1'b0;
      if (w_wr) begin
        w_we_n_nxt  = 1'b0;
        w_drive_nxt = 1'b1;
      end else begin
        w_oe_n_nxt  = 1'b0;
      end
    end else if (w_finish && r_we) begin
      w_drive_nxt = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_we      <= 1'b0;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
      r_rdata   <= '0;
      r_ce_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_bytes_n <= 1'b1;
      r_drive   <= 1'b0;
      r_addr    <= '0;
      r_dout    <= '0;
      for (int i = 0; i < NUM_HEX_WORDS; i++) r_hex[i] <= '0;
    end else begin
      r_ack     <= (w_state_nxt == S_DONE);
      r_busy    <= (w_state_nxt != S_IDLE);
      r_ce_n    <= w_ce_n_nxt;
      r_oe_n    <= w_oe_n_nxt;
      r_we_n    <= w_we_n_nxt;
      r_bytes_n <= w_bytes_n_nxt;
      r_drive   <= w_drive_nxt;
      if (w_accept) begin
        r_we <= bus.we;
        if (!w_is_io) begin
          r_addr <= 20'(bus.addr);
          if (bus.we) r_dout <= bus.wdata;
        end else if (!bus.we) begin
          r_rdata <= w_io_rdata;
        end else if (w_is_hex) begin
          r_hex[w_hex_idx] <= bus.wdata;
        end
      end
      if (w_finish && !r_we) r_rdata <= sram_din;
    end
  end

`ifdef SLC3_MIO_STATS_EN
  // Completed SRAM accesses, saturating; a write to its address clears it
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_stats <= '0;
    end else if (w_accept && w_is_stats && bus.we) begin
      r_stats <= '0;
    end else if (w_finish && (r_stats != 16'hFFFF)) begin
      r_stats <= r_stats + 16'd1;
    end
  end
`endif

  for (genvar g = 0; g < NUM_HEX_WORDS; g++) begin : g_hex
    assign hex_out[g*DATA_W +: DATA_W] = r_hex[g];
  end

  assign bus.ack    = r_ack;
  assign bus.busy   = r_busy;
  assign bus.rdata  = r_rdata;
  assign CE         = r_ce_n;
  assign OE         = r_oe_n;
  assign WE         = r_we_n;
  assign UB         = r_bytes_n;
  assign LB         = r_bytes_n;
  assign ADDR       = r_addr;
  assign sram_dout  = r_dout;
  assign sram_drive = r_drive;

endmodule

// File: tb/tb_slc3_mem_io_ctrl.sv
// Scoreboard bench for slc3_mem_io_ctrl: directed scenarios plus randomized accesses against a word-level model.
module tb_slc3_mem_io_ctrl;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned WS = 2;
  localparam int unsigned NH = 2;
  localparam logic [15:0] SWA = 16'hFFFF;
  localparam logic [15:0] HB  = 16'hFFFA;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  slc3_mem_io_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  logic [DW-1:0]    switches;
  logic [NH*DW-1:0] hex_out;
  logic             CE, OE, WE, UB, LB, sram_drive;
  logic [19:0]      ADDR;
  logic [DW-1:0]    sram_din, sram_dout;

  slc3_mem_io_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS), .NUM_HEX_WORDS(NH),
                     .SW_ADDR(SWA), .HEX_BASE(HB)) dut (
    .Clk(clk), .Reset(rst_n), .bus(bus), .switches(switches), .hex_out(hex_out),
    .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB), .ADDR(ADDR),
    .sram_din(sram_din), .sram_dout(sram_dout), .sram_drive(sram_drive));

  // Behavioural SRAM driven by the DUT strobes
  logic [15:0] sram_mem [0:65535];
  assign sram_din = (!CE && !OE) ? sram_mem[ADDR[15:0]] : 16'hDEAD;
  always @(posedge clk) if (!CE && !WE) sram_mem[ADDR[15:0]] <= sram_dout;

  // Reference model at word level
  logic [15:0] model_mem [0:65535];
  logic [15:0] model_hex [NH];
  int unsigned model_stats;

  typedef struct { logic is_read; logic [15:0] exp; int unsigned issue; int unsigned lat; } exp_t;
  exp_t sbq[$];

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned ce_low = 0, we_low = 0;
  logic [19:0] last_we_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!CE) ce_low = ce_low + 1;
    if (!WE) begin we_low = we_low + 1; last_we_addr = ADDR; end
  end

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (!ok) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every ack consumes one expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.ack) begin
      if (sbq.size() == 0) begin
        check(1'b0, "unexpected_ack", 64'(bus.addr), 64'(0));
      end else begin
        e = sbq.pop_front();
        check((cyc - e.issue + 1) == e.lat, "ack_latency", 64'(cyc - e.issue + 1), 64'(e.lat));
        if (e.is_read) check(bus.rdata == e.exp, "rdata", 64'(bus.rdata), 64'(e.exp));
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bus.busy) return;
    end
    check(1'b0, "idle_timeout", 64'(bus.busy), 64'(0));
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !bus.busy) return;
    end
    check(1'b0, "drain_timeout", 64'(sbq.size()), 64'(0));
  endtask

  // Issue one access; expected outcome comes from the address map rules
  task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d, input bit hold);
    exp_t e;
    bit is_sw, is_hex, is_st;
    int hidx;
    wait_idle();
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    @(posedge clk); #1;
    is_sw  = (a == SWA);
    is_hex = (int'(a) >= int'(HB)) && (int'(a) < int'(HB) + int'(NH));
    hidx   = int'(a) - int'(HB);
`ifdef SLC3_MIO_STATS_EN
    is_st  = (a == 16'hFFF9);
`else
    is_st  = 1'b0;
`endif
    e.issue = cyc; e.is_read = !w; e.exp = '0;
    if (is_sw || is_hex || is_st) begin
      e.lat = 1;
      if (!w) e.exp = is_sw ? switches : is_hex ? model_hex[hidx] : 16'(model_stats);
      else if (is_hex) model_hex[hidx] = d;
      else if (is_st)  model_stats = 0;
    end else begin
      e.lat = WS + 2;
      if (w) model_mem[a] = d; else e.exp = model_mem[a];
      if (model_stats < 32'hFFFF) model_stats = model_stats + 1;
    end
    sbq.push_back(e);
    if (!hold) bus.req = 1'b0;
  endtask

  function automatic logic [NH*DW-1:0] model_hex_vec();
    logic [NH*DW-1:0] v;
    for (int i = 0; i < NH; i++) v[i*DW +: DW] = model_hex[i];
    return v;
  endfunction

  initial begin
    logic [15:0] pool [6];
    int unsigned ce0, we0;
    int r;
    pool[0] = 16'h0000; pool[1] = 16'h0010; pool[2] = 16'h1234;
    pool[3] = 16'hFFF0; pool[4] = 16'hFFF8; pool[5] = 16'hFFF9;
    for (int i = 0; i < 65536; i++) begin sram_mem[i] = '0; model_mem[i] = '0; end
    for (int i = 0; i < NH; i++) model_hex[i] = '0;
    model_stats = 0;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; switches = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check({bus.ack, bus.busy, CE, OE, WE, UB, LB, sram_drive} == 8'b0011_1110, "reset_ctrl",
          64'({bus.ack, bus.busy, CE, OE, WE, UB, LB, sram_drive}), 64'(8'b0011_1110));
    check(bus.rdata == '0 && ADDR == '0 && sram_dout == '0, "reset_data",
          64'({bus.rdata, ADDR, sram_dout}), 64'(0));
    check(hex_out == '0, "reset_hex", 64'(hex_out), 64'(0));

    // SRAM write then read back
    we0 = we_low;
    access(1'b1, 16'h0010, 16'hBEEF, 1'b0);
    drain();
    check(we_low - we0 == WS + 1, "we_low_cycles", 64'(we_low - we0), 64'(WS + 1));
    check(last_we_addr == 20'h00010, "sram_addr", 64'(last_we_addr), 64'(20'h00010));
    access(1'b0, 16'h0010, 16'h0000, 1'b0);
    drain();

    // Switch register: read without SRAM strobes, write dropped but acked
    switches = 16'h1234;
    ce0 = ce_low;
    access(1'b0, SWA, 16'h0000, 1'b0);
    access(1'b1, SWA, 16'h5555, 1'b0);
    drain();
    check(ce_low == ce0, "io_no_ce", 64'(ce_low - ce0), 64'(0));
    check(hex_out == model_hex_vec(), "sw_write_no_effect", 64'(hex_out), 64'(model_hex_vec()));

    // Hex display register
    access(1'b1, HB + 16'd1, 16'hA5C3, 1'b0);
    drain();
    check(hex_out == model_hex_vec(), "hex_write", 64'(hex_out), 64'(model_hex_vec()));
    access(1'b0, HB + 16'd1, 16'h0000, 1'b0);
    drain();

    // req pulsed while busy is ignored
    access(1'b1, 16'h0020, 16'h1111, 1'b0);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'h0030; bus.wdata = 16'hBAD0;
    @(negedge clk);
    bus.req = 1'b0;
    drain();
    access(1'b0, 16'h0030, 16'h0000, 1'b0);
    drain();

    // req held across ack starts a second access
    access(1'b0, 16'h0010, 16'h0000, 1'b1);
    access(1'b0, 16'h0020, 16'h0000, 1'b0);
    check(bus.busy == 1'b1, "busy_reassert", 64'(bus.busy), 64'(1));
    drain();

`ifdef SLC3_MIO_STATS_EN
    access(1'b1, 16'hFFF9, 16'h0000, 1'b0);
    access(1'b1, 16'h0040, 16'h0001, 1'b0);
    access(1'b0, 16'h0040, 16'h0000, 1'b0);
    access(1'b0, 16'h0000, 16'h0000, 1'b0);
    access(1'b0, 16'hFFF9, 16'h0000, 1'b0);
    access(1'b1, 16'hFFF9, 16'h0000, 1'b0);
    access(1'b0, 16'hFFF9, 16'h0000, 1'b0);
    drain();
`endif

    // Randomized mix of SRAM and IO accesses
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 3)      access(1'($urandom_range(0, 1)), pool[$urandom_range(0, 5)], 16'($urandom()), 1'b0);
      else if (r == 4) begin wait_idle(); switches = 16'($urandom()); access(1'b0, SWA, 16'h0000, 1'b0); end
      else if (r == 5) access(1'b1, SWA, 16'($urandom()), 1'b0);
      else if (r <= 7) access(1'b1, HB + 16'($urandom_range(0, NH - 1)), 16'($urandom()), 1'b0);
      else if (r == 8) access(1'($urandom_range(0, 1)), 16'hFFF9, 16'($urandom()), 1'b0);
      else             access(1'b0, HB + 16'($urandom_range(0, NH - 1)), 16'h0000, 1'b0);
    end
    drain();
    check(hex_out == model_hex_vec(), "hex_after_random", 64'(hex_out), 64'(model_hex_vec()));

    // Async reset in the middle of an SRAM write
    wait_idle();
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'h7777; bus.wdata = 16'h9999;
    @(posedge clk); #1;
    bus.req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check({CE, WE, sram_drive, bus.busy, bus.ack} == 5'b11000, "reset_mid_access",
          64'({CE, WE, sram_drive, bus.busy, bus.ack}), 64'(5'b11000));
    for (int i = 0; i < NH; i++) model_hex[i] = '0;
    model_stats = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check(hex_out == model_hex_vec() && !bus.busy, "after_reset",
          64'({bus.busy, hex_out}), 64'(model_hex_vec()));
    access(1'b0, 16'h0010, 16'h0000, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
